// File: rtl/fwd_pkg.sv
// Shared forwarding constants and helpers used by the operand muxes, register file and hazard unit.
package fwd_pkg;

  localparam int unsigned FWD_WIDTH  = 32;
  localparam int unsigned FWD_REG_AW = 5;
  localparam int unsigned FWD_SEL_RF = 0;

  // Producer i is reported on out_sel as i+1; 0 is reserved for the register file.
  function automatic int unsigned fwd_sel_of(input int unsigned i);
    return i + 32'd1;
  endfunction

endpackage

// File: rtl/fwd_prio_enc.sv
// Lowest-index-wins priority encoder over the forwarding hit vector.
module fwd_prio_enc #(
  parameter int unsigned NUM_FW = 3,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_FW-1:0] hit,
  output logic              hit_any,
  output logic [IDX_W-1:0]  winner
);

  // Scan from the oldest producer down so the youngest match overwrites.
  always_comb begin
    hit_any = |hit;
    winner  = '0;
    for (int i = int'(NUM_FW) - 1; i >= 0; i--) begin
      if (hit[i]) winner = IDX_W'(i);
    end
  end

endmodule

// File: rtl/fwd_operand_mux.sv
// Resolves one EX source operand from the register file or a forwarding producer, with load-use stall
// and a single registered output slot. Optional counters under FWD_OPERAND_STATS_EN.
module fwd_operand_mux
  import fwd_pkg::*;
#(
  parameter int unsigned WIDTH  = FWD_WIDTH,
  parameter int unsigned NUM_FW = 3,
  parameter int unsigned REG_AW = FWD_REG_AW,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_AW-1:0]        src_reg,
  input  logic [WIDTH-1:0]         rf_data,
  input  logic [NUM_FW-1:0]        fw_valid,
  input  logic [NUM_FW*REG_AW-1:0] fw_rd,
  input  logic [NUM_FW*WIDTH-1:0]  fw_data,
  input  logic [NUM_FW-1:0]        fw_rdy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     stall
`ifdef FWD_OPERAND_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [31:0]              fwd_cnt,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_FW > 1) ? $clog2(NUM_FW) : 1;

  logic [NUM_FW-1:0] hit;
  logic              hit_any;
  logic [IDX_W-1:0]  winner;
  logic              win_rdy;
  logic [WIDTH-1:0]  win_data;
  logic [SEL_W-1:0]  sel_next;
  logic              capture;

  // Register 0 is hardwired and never forwards.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_FW); i++) begin
      hit[i] = fw_valid[i] && (fw_rd[i*REG_AW +: REG_AW] == src_reg) && (src_reg != '0);
    end
  end

  fwd_prio_enc #(
    .NUM_FW (NUM_FW),
    .IDX_W  (IDX_W)
  ) u_prio (
    .hit     (hit),
    .hit_any (hit_any),
    .winner  (winner)
  );

  always_comb begin
    win_rdy  = 1'b0;
    win_data = '0;
    for (int i = 0; i < int'(NUM_FW); i++) begin
      if (winner == IDX_W'(i)) begin
        win_rdy  = fw_rdy[i];
        win_data = fw_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only the winning producer matters: an older ready producer cannot mask a pending load.
  assign stall    = in_valid && hit_any && !win_rdy;
  assign in_ready = !stall && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;
  assign sel_next = hit_any ? SEL_W'(fwd_sel_of(32'(winner))) : SEL_W'(FWD_SEL_RF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= hit_any ? win_data : rf_data;
      out_sel   <= sel_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FWD_OPERAND_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt   <= '0;
      stall_cnt <= '0;
    end else if (stats_clr) begin
      fwd_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (capture && hit_any) fwd_cnt <= fwd_cnt + 32'd1;
      if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_operand_mux.sv
// Directed self-checking bench for fwd_operand_mux (NUM_FW=3, WIDTH=32, REG_AW=5).
module tb_fwd_operand_mux;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NUM_FW = 3;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [REG_AW-1:0]        src_reg;
  logic [WIDTH-1:0]         rf_data;
  logic [NUM_FW-1:0]        fw_valid;
  logic [NUM_FW*REG_AW-1:0] fw_rd;
  logic [NUM_FW*WIDTH-1:0]  fw_data;
  logic [NUM_FW-1:0]        fw_rdy;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     stall;
`ifdef FWD_OPERAND_STATS_EN
  logic                     stats_clr;
  logic [31:0]              fwd_cnt;
  logic [31:0]              stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_operand_mux #(
    .WIDTH  (WIDTH),
    .NUM_FW (NUM_FW),
    .REG_AW (REG_AW),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_reg   (src_reg),
    .rf_data   (rf_data),
    .fw_valid  (fw_valid),
    .fw_rd     (fw_rd),
    .fw_data   (fw_data),
    .fw_rdy    (fw_rdy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .stall     (stall)
`ifdef FWD_OPERAND_STATS_EN
    ,
    .stats_clr (stats_clr),
    .fwd_cnt   (fwd_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic set_fw(input int i, input logic v, input logic [REG_AW-1:0] rd,
                        input logic [WIDTH-1:0] d, input logic r);
    fw_valid[i]                = v;
    fw_rd[i*REG_AW +: REG_AW]  = rd;
    fw_data[i*WIDTH +: WIDTH]  = d;
    fw_rdy[i]                  = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    src_reg   = '0;
    rf_data   = '0;
    fw_valid  = '0;
    fw_rd     = '0;
    fw_data   = '0;
    fw_rdy    = '0;
    out_ready = 1'b1;
`ifdef FWD_OPERAND_STATS_EN
    stats_clr = 1'b0;
`endif
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // No hit: register file selected
    src_reg = 5'd5; rf_data = 32'h1111_1111; in_valid = 1'b1;
    #1;
    check("nohit_in_ready", 32'(in_ready), 32'd1);
    step();
    check("nohit_out_valid", 32'(out_valid), 32'd1);
    check("nohit_out_data", out_data, 32'h1111_1111);
    check("nohit_out_sel", 32'(out_sel), 32'd0);

    // Priority: producers 0 and 2 both target r7
    src_reg = 5'd7;
    set_fw(0, 1'b1, 5'd7, 32'hAAAA_0000, 1'b1);
    set_fw(1, 1'b1, 5'd3, 32'hBBBB_0000, 1'b1);
    set_fw(2, 1'b1, 5'd7, 32'hCCCC_0000, 1'b1);
    step();
    check("prio_out_data", out_data, 32'hAAAA_0000);
    check("prio_out_sel", 32'(out_sel), 32'd1);

    // Only the oldest producer matches
    set_fw(0, 1'b1, 5'd9, 32'hAAAA_0000, 1'b1);
    step();
    check("old_out_data", out_data, 32'hCCCC_0000);
    check("old_out_sel", 32'(out_sel), 32'd3);

    // Load-use: youngest match not ready, older match ready
    set_fw(0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_in_ready", 32'(in_ready), 32'd0);
    step();
    check("lu_no_capture_valid", 32'(out_valid), 32'd0);
    check("lu_held_data", out_data, 32'hCCCC_0000);
    check("lu_held_sel", 32'(out_sel), 32'd3);
    set_fw(0, 1'b1, 5'd7, 32'h1234_5678, 1'b1);
    #1;
    check("lu_release_stall", 32'(stall), 32'd0);
    check("lu_release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("lu_out_valid", 32'(out_valid), 32'd1);
    check("lu_out_data", out_data, 32'h1234_5678);
    check("lu_out_sel", 32'(out_sel), 32'd1);

    // Register 0 never forwards, even from a not-ready producer
    src_reg = 5'd0; rf_data = 32'h0;
    set_fw(0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    #1;
    check("r0_stall", 32'(stall), 32'd0);
    step();
    check("r0_out_data", out_data, 32'h0);
    check("r0_out_sel", 32'(out_sel), 32'd0);

    // Backpressure
    fw_valid = '0;
    src_reg = 5'd9; rf_data = 32'h3333_3333;
    step();
    check("bp_first_data", out_data, 32'h3333_3333);
    out_ready = 1'b0;
    rf_data = 32'h2222_2222;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", out_data, 32'h3333_3333);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_replace_valid", 32'(out_valid), 32'd1);
    check("bp_replace_data", out_data, 32'h2222_2222);
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data_kept", out_data, 32'h2222_2222);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; rf_data = 32'h4444_4444; src_reg = 5'd4;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_out_sel", 32'(out_sel), 32'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

`ifdef FWD_OPERAND_STATS_EN
    check("stats_rst_fwd", fwd_cnt, 32'd0);
    check("stats_rst_stall", stall_cnt, 32'd0);
    src_reg = 5'd7;
    set_fw(0, 1'b1, 5'd7, 32'h5555_5555, 1'b1);
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) step();
    fw_rdy[0] = 1'b0;
    for (int c = 0; c < 2; c++) step();
    in_valid = 1'b0;
    #1;
    check("stats_fwd_cnt", fwd_cnt, 32'd4);
    check("stats_stall_cnt", stall_cnt, 32'd2);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("stats_clr_fwd", fwd_cnt, 32'd0);
    check("stats_clr_stall", stall_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_operand_mux.md
Name: fwd_operand_mux

Overview:
- Parametrised successor to the pipeline's fixed 3:1 forwarding mux.
- Resolves one source operand for the execute stage by choosing between register-file data and up to NUM_FW later-stage producer results, by address match and priority.
- Detects load-use hazards and raises stall.
- Holds the resolved operand in a registered output slot with a valid/ready handshake toward EX.

Parameters:
- WIDTH, 32, operand/data width in bits
- NUM_FW, 3, number of forwarding producers; index 0 is the youngest stage (EX/MEM) and has highest priority
- REG_AW, 5, register address width
- SEL_W, 2, width of out_sel; must satisfy 2^SEL_W >= NUM_FW+1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode stage presents an operand request
- in_ready  out  1  request accepted this cycle
- src_reg  in  REG_AW  source register address
- rf_data  in  WIDTH  register-file read data for src_reg
- fw_valid  in  NUM_FW  producer i writes a register
- fw_rd  in  NUM_FW*REG_AW  producer destination addresses, packed, i at [i*REG_AW +: REG_AW]
- fw_data  in  NUM_FW*WIDTH  producer results, packed likewise
- fw_rdy  in  NUM_FW  producer i result is available this cycle (0 = load still in flight)
- out_valid  out  1  resolved operand held
- out_ready  in  1  EX consumes operand
- out_data  out  WIDTH  resolved operand
- out_sel  out  SEL_W  source used: 0 = register file, i+1 = producer i
- stall  out  1  hazard; upstream must hold request

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous active-low, rst_n.
- Reset values: out_valid=0, out_data=0, out_sel=0. stall and in_ready are combinational; with in_valid=0 they give stall=0 and in_ready=1.
- Match, combinational: hit[i] = fw_valid[i] && fw_rd[i]==src_reg && src_reg!=0.
  - Register 0 never forwards; it always selects rf_data.
- Priority: the lowest index i with hit[i] wins. Older matching producers are ignored.
- Hazard: stall = in_valid && the winning hit exists && !fw_rdy[winner].
  - A not-ready winner stalls even if an older producer is ready.
- in_ready = !stall && (!out_valid || out_ready). Single output slot, so full throughput with a pass-through ready.
- Capture when in_valid && in_ready:
  - out_data = fw_data[winner] if a hit exists, otherwise rf_data
  - out_sel = winner+1 if a hit exists, otherwise 0
  - out_valid = 1
- Latency: exactly 1 cycle from accept to out_valid.
- out_valid && out_ready && no new capture -> out_valid=0. out_data and out_sel keep their last value.
- Simultaneous consume and capture in the same cycle: the new operand replaces the old one and out_valid stays 1.
- Output stability: out_valid && !out_ready -> out_data and out_sel are held, and in_ready=0.
- During stall nothing is captured. The held output is unaffected and may still be consumed.
- Reset mid-operation: the slot clears immediately (asynchronous). Any pending request is dropped, and upstream re-presents it.
- Unused out_sel encodings (> NUM_FW) are never produced.

Optional Feature:
- Macro: FWD_OPERAND_STATS_EN
- Defined, the block adds:
  - output fwd_cnt [31:0]: increments on each capture with out_sel != 0
  - output stall_cnt [31:0]: increments on each cycle stall=1
  - input stats_clr: synchronous clear of both counters; clear takes precedence over increment
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist, and the core behaviour is identical.

Decomposition:
- Shared package fwd_pkg:
  - FWD_SEL_RF=0 constant
  - function fwd_sel_of(i) returning i+1
  - default WIDTH/REG_AW constants shared with the register file and hazard unit
- One sub-module, fwd_prio_enc: a NUM_FW-bit priority encoder outputting hit_any and winner index. It is reused by the second operand instance.
- Operand slot and stats counters stay in fwd_operand_mux.

Test Plan:
- No hit: src_reg=5, rf_data=0x11111111, fw_valid=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=0x11111111, out_sel=0.
- Priority: src_reg=7, producers 0 and 2 both rd=7, ready, data 0xAAAA0000 / 0xCCCC0000 -> out_data=0xAAAA0000, out_sel=1.
- Load-use: producer 0 rd=7, fw_rdy[0]=0 -> stall=1, in_ready=0, no capture; then fw_rdy[0]=1 with data 0x12345678 -> stall=0 and one cycle later out_data=0x12345678, out_sel=1.
- Register 0: src_reg=0, producer 0 rd=0 ready with data 0xFFFFFFFF, rf_data=0 -> out_data=0, out_sel=0, stall=0.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_data held for 3 cycles; out_ready=1 with a new request the same cycle -> replaced with no bubble.
- Reset mid-stream: drop rst_n while out_valid=1 -> out_valid=0, out_data=0 immediately, without waiting for a clock edge. With FWD_OPERAND_STATS_EN, 4 forwarded captures plus 2 stall cycles -> fwd_cnt=4, stall_cnt=2; stats_clr -> both 0.
